// File: rtl/uart_frame_pkg.sv
// Shared UART framing definitions, used by both the transmitter and the receiver.
package uart_frame_pkg;
  localparam int   FRAME_BITS  = 10;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} tx_state_e;
endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with a registered occupancy count.
// The read data always shows the head entry.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] wr_data,
  input  logic       pop,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          wr_en, rd_en;

  assign wr_en   = push & ~full;
  assign rd_en   = pop & ~empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/serial_byte_tx.sv
// Byte-to-serial transmitter: 8N1 frames, one bit per clk, optional idle gap.
// The line flop follows the FSM state by one cycle, so out lags state.
module serial_byte_tx
  import uart_frame_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int IDLE_GAP   = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_byte,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out,
  output logic       busy
);
  localparam int GW = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;

  tx_state_e     state, state_nx;
  logic [2:0]    bit_idx;
  logic [GW-1:0] gap_cnt;
  logic [7:0]    shreg;
  logic          rdy_q;
  logic          push, pop;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_data;

  // rdy_q keeps in_ready low until the first edge after reset is released.
  assign in_ready = rdy_q & ~fifo_full;
  assign push     = in_valid & in_ready;
  assign busy     = (state != IDLE) | ~fifo_empty;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (in_byte),
    .pop     (pop),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      IDLE: if (!fifo_empty) begin
        state_nx = START;
        pop      = 1'b1;
      end
      START: state_nx = DATA;
      DATA:  if (bit_idx == 3'd7) state_nx = STOP;
      STOP: begin
        if (IDLE_GAP > 0) begin
          state_nx = GAP;
        end else if (!fifo_empty) begin
          state_nx = START;
          pop      = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      GAP: if (gap_cnt == GW'(IDLE_GAP - 1)) begin
        if (!fifo_empty) begin
          state_nx = START;
          pop      = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bit_idx <= '0;
      gap_cnt <= '0;
      shreg   <= '0;
      rdy_q   <= 1'b0;
      out     <= 1'b1;
    end else begin
      state <= state_nx;
      rdy_q <= 1'b1;

      if (pop)                shreg <= fifo_data;
      else if (state == DATA) shreg <= {1'b0, shreg[7:1]};

      // Natural 3-bit wrap lands on the DATA->STOP edge.
      if (state == DATA) bit_idx <= bit_idx + 1'b1;

      if (state == GAP && state_nx == GAP) gap_cnt <= gap_cnt + 1'b1;
      else                                 gap_cnt <= '0;

      case (state)
        START:   out <= START_LEVEL;
        DATA:    out <= shreg[0];
        STOP:    out <= STOP_LEVEL;
        default: out <= 1'b1;
      endcase
    end
  end
endmodule

// File: doc/serial_byte_tx.md
SERIAL_BYTE_TX -- requirements
Module: serial_byte_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: byte FIFO entries, power of two, minimum 2.
REQ-002 SHALL have parameter IDLE_GAP, default 0: minimum number of idle-high bit times inserted after each stop bit.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_byte  input  8  byte to transmit, sampled on accept.
REQ-006 SHALL have port in_valid  input  1  in_byte is valid this cycle.
REQ-007 SHALL have port in_ready  output  1  FIFO can accept a byte this cycle.
REQ-008 SHALL have port out  output  1  serial line, one bit per clk; idle level 1.
REQ-009 SHALL have port busy  output  1  a frame is in flight or the FIFO is non-empty.

Function
REQ-010 SHALL accept a byte on any rising edge where in_valid and in_ready are both 1, and SHALL ignore in_byte otherwise.
REQ-011 SHALL drive in_ready = 1 exactly when the FIFO holds fewer than FIFO_DEPTH bytes, with no combinational path from in_valid; no push when full, even if a pop occurs that cycle.
REQ-012 SHALL emit each frame as 10 consecutive bit times: start 0, data bits 0..7 LSB first, stop 1.
REQ-013 SHALL drive out from a flop, never combinationally.
REQ-014 SHALL use FSM states IDLE, START, DATA, STOP, GAP.
REQ-015 SHALL use FSM transitions: IDLE->START when FIFO non-empty (pop on that edge); START->DATA; DATA->DATA while bit index < 7, else ->STOP; STOP->GAP if IDLE_GAP > 0; STOP->START with pop if IDLE_GAP = 0 and FIFO non-empty; STOP->IDLE otherwise; GAP->START/IDLE after IDLE_GAP cycles by the same FIFO test.
REQ-016 SHALL use a 3-bit bit-index counter that wraps 7->0 only on DATA->STOP.
REQ-017 SHALL use a gap counter of width $clog2(IDLE_GAP+1).
REQ-018 SHALL time a byte accepted at edge E into an empty FIFO with FSM in IDLE as: start bit on out after edge E+2, data bit i after edge E+3+i, stop bit after edge E+11.
REQ-019 SHALL send back-to-back frames with no idle bit between stop and the next start when IDLE_GAP = 0 and data is queued.
REQ-020 SHALL handle a simultaneous push and pop in one cycle with the FIFO count unchanged and data order preserved.
REQ-021 SHALL hold out = 1 in IDLE and GAP.
REQ-022 SHALL drive busy = 0 only when the FSM is in IDLE and the FIFO is empty.

Reset
REQ-023 SHALL, on reset assertion, asynchronously force: out = 1, FSM = IDLE, FIFO empty, counters = 0, busy = 0, in_ready = 0.
REQ-024 SHALL drive in_ready = 1 from the first rising edge after reset deasserts.
REQ-025 SHALL, on reset mid-frame, truncate the frame immediately (line returns high) and discard all queued bytes.

Structure
REQ-026 SHALL place the state enum, FRAME_BITS = 10, START_LEVEL = 0 and STOP_LEVEL = 1 in shared package uart_frame_pkg, for reuse by the receiver side.
REQ-027 SHALL implement the FIFO as sub-module byte_fifo: synchronous, parameterised depth, registered count, full/empty flags, asynchronous reset.
REQ-028 SHALL keep the FSM, shift register and counters in serial_byte_tx.

Verification
REQ-029 SHALL cover single byte: push 0xA5 when idle -> out = 0,1,0,1,0,0,1,0,1,1 starting edge E+2, then 1; busy falls after the stop bit.
REQ-030 SHALL cover back-to-back with IDLE_GAP = 0: push 0x00, 0xFF on consecutive cycles -> 20 bits: 0, eight 0s, 1, 0, eight 1s, 1; no idle bit between the frames.
REQ-031 SHALL cover backpressure with FIFO_DEPTH = 4: hold in_valid for 8 bytes 0x10..0x17 -> in_ready drops when 4 are queued; all 8 transmitted in order with none lost or duplicated.
REQ-032 SHALL cover IDLE_GAP = 2: two queued bytes -> exactly 2 high bit times between the first stop bit and the second start bit.
REQ-033 SHALL cover reset mid-frame: assert reset during data bit 3 with 2 bytes queued -> out = 1 immediately; after release no further frame and busy = 0.
REQ-034 SHALL cover loopback: out feeds the team's serial receiver, 256 random bytes sent -> receiver done pulses 256 times with out_byte matching in order.
